// File: rtl/mult_operand_feeder.sv
// Operand FIFO, start/count sequencer, result slot and watchdog sitting beside
// the 8x8 sequential multiplier control and datapath.
module mult_operand_feeder #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  dataa,
    output logic [7:0]  datab,
    output logic        start,
    output logic [1:0]  count,
    input  logic        done,
    input  logic [15:0] product,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     mem_q [DEPTH];
    logic [7:0]      dataa_q, datab_q;
    logic [1:0]      count_q, count_d;
    logic [7:0]      wd_q, wd_d;
    logic            res_valid_q, res_valid_d;
    logic [15:0]     res_data_q, res_data_d;
    logic            err_q, err_d;
    logic            push, pop, res_read, capture;

    assign in_ready = (cnt_q != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign res_read = res_valid_q & res_ready;

    // A new operation may only start once the result slot is free or being drained.
    always_comb begin
        state_d = state_q;
        count_d = 2'd0;
        wd_d    = wd_q;
        err_d   = err_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if ((cnt_q != '0) && (!res_valid_q || res_ready)) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = RUN;
                wd_d    = 8'd0;
            end
            RUN: begin
                count_d = count_q + 2'd1;
                if (done) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (wd_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = product;
        end else if (res_read) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            dataa_q     <= 8'd0;
            datab_q     <= 8'd0;
            count_q     <= 2'd0;
            wd_q        <= 8'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                dataa_q  <= mem_q[rd_ptr_q][15:8];
                datab_q  <= mem_q[rd_ptr_q][7:0];
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dataa     = dataa_q;
    assign datab     = datab_q;
    assign start     = (state_q == LAUNCH);
    assign count     = count_q;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mult_operand_feeder.sv
// Directed bench for mult_operand_feeder with a behavioural multiplier control
// (LSB, MID, MID, MSB, CALC_DONE) and an ideal product datapath.
module tb_mult_operand_feeder;
    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic [7:0]  dataa, datab;
    logic        start;
    logic [1:0]  count;
    logic        done;
    logic [15:0] product;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        busy, err;

    logic        gate_done = 1'b1;
    logic        force_done = 1'b0;
    logic [2:0]  ctl_q;
    int          total = 0;
    int          bad = 0;

    mult_operand_feeder #(.DEPTH(2), .TIMEOUT(15)) dut (
        .clk(clk), .reset_a(reset_a), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .dataa(dataa), .datab(datab), .start(start),
        .count(count), .done(done), .product(product), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Control model: start -> 1..5, done asserted in state 5 (CALC_DONE).
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) ctl_q <= 3'd0;
        else if (start) ctl_q <= 3'd1;
        else if (ctl_q != 3'd0 && ctl_q < 3'd5) ctl_q <= ctl_q + 3'd1;
        else ctl_q <= 3'd0;
    end
    assign done    = (gate_done && ctl_q == 3'd5) || force_done;
    assign product = {8'd0, dataa} * {8'd0, datab};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_res(input int maxc, input string tag);
        int k = 0;
        while (!res_valid && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(tag, res_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        cyc(2);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_count", count, 0);
        chk("rst_dataa", dataa, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset_a = 1'b0;
        cyc(1);

        // Single op: FF*FF, result valid 7 edges after acceptance
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
        cyc(1);
        in_valid = 1'b0;
        chk("t2_n1_busy", busy, 0);
        chk("t2_n1_in_ready", in_ready, 1);
        cyc(1);
        chk("t2_start_hi", start, 1);
        chk("t2_launch_count", count, 0);
        chk("t2_dataa", dataa, 8'hFF);
        chk("t2_datab", datab, 8'hFF);
        cyc(1);
        chk("t2_start_lo", start, 0);
        chk("t2_count0", count, 0);
        chk("t2_busy", busy, 1);
        cyc(1); chk("t2_count1", count, 1);
        cyc(1); chk("t2_count2", count, 2);
        cyc(1); chk("t2_count3", count, 3);
        cyc(1); chk("t2_rv_early", res_valid, 0);
        cyc(1);
        chk("t2_rv_7", res_valid, 1);
        chk("t2_data", res_data, 16'hFE01);
        chk("t2_idle", busy, 0);
        res_ready = 1'b1;
        cyc(1);
        chk("t2_read", res_valid, 0);
        res_ready = 1'b0;

        // FIFO fill with consumer stalled
        in_valid = 1'b1; in_a = 8'h03; in_b = 8'h05;
        cyc(1);
        chk("t3_rdy1", in_ready, 1);
        in_a = 8'h07; in_b = 8'h09;
        cyc(1);
        chk("t3_start1", start, 1);
        chk("t3_rdy2", in_ready, 1);
        in_a = 8'h10; in_b = 8'h20;
        cyc(1);
        chk("t3_full", in_ready, 0);
        in_valid = 1'b0;
        wait_res(10, "t3_r1_valid");
        chk("t3_r1_data", res_data, 16'h000F);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t3_withheld", start, 0);
            chk("t3_still_full", in_ready, 0);
        end
        res_ready = 1'b1;
        cyc(1);
        res_ready = 1'b0;
        chk("t3_read1", res_valid, 0);
        chk("t3_start2", start, 1);
        chk("t3_dataa2", dataa, 8'h07);
        chk("t3_rdy_after_pop", in_ready, 1);
        wait_res(10, "t3_r2_valid");
        chk("t3_r2_data", res_data, 16'h003F);

        // Read + pop + push on one edge; streaming consumer
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h11;
        cyc(1);
        in_valid = 1'b0;
        chk("t4_start3", start, 1);
        chk("t4_dataa3", dataa, 8'h10);
        chk("t4_read2", res_valid, 0);
        wait_res(10, "t4_r3_valid");
        chk("t4_r3_data", res_data, 16'h0200);
        cyc(1);
        chk("t4_start4", start, 1);
        chk("t4_dataa4", dataa, 8'h11);
        chk("t4_read3", res_valid, 0);
        wait_res(10, "t4_r4_valid");
        chk("t4_r4_data", res_data, 16'h0121);
        cyc(1);
        chk("t4_read4", res_valid, 0);
        cyc(2);
        chk("t4_empty_idle", busy, 0);

        // Watchdog: done suppressed for the first op
        gate_done = 1'b0;
        in_valid = 1'b1; in_a = 8'h02; in_b = 8'h03;
        cyc(1);
        in_a = 8'h04; in_b = 8'h05;
        cyc(1);
        in_valid = 1'b0;
        cyc(15);
        chk("t5_err_not_yet", err, 0);
        chk("t5_busy_14", busy, 1);
        cyc(1);
        chk("t5_err_set", err, 1);
        chk("t5_idle", busy, 0);
        chk("t5_no_result", res_valid, 0);
        chk("t5_data_kept", res_data, 16'h0121);
        gate_done = 1'b1;
        cyc(1);
        chk("t5_next_start", start, 1);
        chk("t5_next_dataa", dataa, 8'h04);
        wait_res(10, "t5_next_valid");
        chk("t5_next_data", res_data, 16'h0014);
        chk("t5_err_sticky", err, 1);
        cyc(1);
        chk("t5_read", res_valid, 0);

        // Stray done in IDLE and LAUNCH
        force_done = 1'b1;
        cyc(3);
        chk("t6_idle_nocap", res_valid, 0);
        chk("t6_idle_state", busy, 0);
        in_valid = 1'b1; in_a = 8'h06; in_b = 8'h07;
        cyc(1);
        in_valid = 1'b0;
        cyc(1);
        chk("t6_launch", start, 1);
        cyc(1);
        force_done = 1'b0;
        chk("t6_run", busy, 1);
        chk("t6_launch_nocap", res_valid, 0);
        chk("t6_run_start_lo", start, 0);
        wait_res(10, "t6_valid");
        chk("t6_data", res_data, 16'h002A);

        // Asynchronous reset mid-RUN with a pair still queued
        cyc(1);
        in_valid = 1'b1; in_a = 8'h09; in_b = 8'h09;
        cyc(1);
        in_a = 8'h21; in_b = 8'h21;
        cyc(1);
        in_valid = 1'b0;
        cyc(2);
        chk("t1_pre_busy", busy, 1);
        chk("t1_pre_err", err, 1);
        #2 reset_a = 1'b1;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_start", start, 0);
        chk("t1_count", count, 0);
        chk("t1_dataa", dataa, 0);
        chk("t1_datab", datab, 0);
        chk("t1_res_valid", res_valid, 0);
        chk("t1_res_data", res_data, 0);
        chk("t1_err", err, 0);
        chk("t1_in_ready", in_ready, 1);
        @(negedge clk);
        reset_a = 1'b0;
        cyc(4);
        chk("t1_fifo_empty", busy, 0);
        chk("t1_no_result", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
